interrupt_sequencer: RTL and testbench

Conditions the four CPU interrupt sources before they reach the CPU's int1..int4 inputs. Each raw source (external pins int1..int3 and the FSX frameDrawn strobe, which is not yet stabilized) is synchronized, rising-edge detected, latched as pending, and replayed to the CPU as a clean fixed-width pulse. At most one output pulse is active at a time, separated by a guaranteed gap. Lost events are recorded in sticky flags.

---
 rtl/interrupt_sequencer.sv | 120 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt conditioning for CPU int1..int4: synchronizes four raw sources,
// latches rising edges as pending events, and replays them one at a time as
// fixed-width pulses separated by a guaranteed idle gap. Lost events are
// recorded in sticky flags.
module interrupt_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] int_in,
  input  logic [3:0] int_mask,
  input  logic       clear_lost,
  output logic [3:0] int_out,
  output logic [3:0] pending,
  output logic [3:0] lost,
  output logic       busy
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [3:0]    s1, s2, s3;
  logic [3:0]    rise, avail, sel, clr;
  logic [3:0]    out_nx, pending_nx, lost_nx;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= int_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Enabled rising edges, serviceable events, and lowest-index selection
  always_comb begin
    rise  = s2 & ~s3 & int_mask;
    avail = pending & int_mask;
    sel   = avail & (~avail + 4'd1);
  end

  // Sequencer next state: choose in IDLE, time the pulse, then time the gap
  always_comb begin
    state_nx = state;
    count_nx = count;
    out_nx   = int_out;
    clr      = '0;
    unique case (state)
      IDLE: begin
        if (avail != '0) begin
          state_nx = PULSE;
          out_nx   = sel;
          clr      = sel;
          count_nx = CW'(PULSE_CYCLES - 1);
        end
      end
      PULSE: begin
        if (count == '0) begin
          state_nx = GAP;
          out_nx   = '0;
          count_nx = CW'(GAP_CYCLES - 1);
        end else begin
          count_nx = count - CW'(1);
        end
      end
      GAP: begin
        if (count == '0) begin
          state_nx = IDLE;
        end else begin
          count_nx = count - CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        out_nx   = '0;
        count_nx = '0;
      end
    endcase
  end

  // Event bookkeeping: a new edge outranks the selection clear and the lost clear
  always_comb begin
    pending_nx = (pending & ~clr) | rise;
    lost_nx    = (lost & ~{4{clear_lost}}) | (rise & pending & ~clr);
  end

  // Registered sequencer state and event flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      int_out <= '0;
      pending <= '0;
      lost    <= '0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      int_out <= out_nx;
      pending <= pending_nx;
      lost    <= lost_nx;
    end
  end

  // Busy covers both the pulse and the enforced gap
  always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against an
// event/timestamp model of the sequencing rules.
module tb_interrupt_sequencer;

  localparam int P = 4;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] int_in;
  logic [3:0] int_mask;
  logic       clear_lost;
  logic [3:0] int_out;
  logic [3:0] pending;
  logic [3:0] lost;
  logic       busy;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (rst),
    .int_in    (int_in),
    .int_mask  (int_mask),
    .clear_lost(clear_lost),
    .int_out   (int_out),
    .pending   (pending),
    .lost      (lost),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Sample history of int_in (1, 2, 3 edges ago), event flags, and the
  // timestamps of the current pulse and of the earliest next selection.
  logic [3:0] h1 = '0, h2 = '0, h3 = '0;
  logic [3:0] m_pend = '0, m_lost = '0;
  int         m_now = 0, m_start = 0, m_free = 0, m_src = 0;
  bit         m_act = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] r, c;
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_lost = '0;
      m_now = 0; m_start = 0; m_free = 0; m_src = 0; m_act = 1'b0;
    end else begin
      m_now++;
      r = h2 & ~h3 & int_mask;
      c = '0;
      if (m_now >= m_free && (m_pend & int_mask) != 4'b0) begin
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && int_mask[i]) m_src = i;
        c[m_src] = 1'b1;
        m_start  = m_now;
        m_act    = 1'b1;
        m_free   = m_now + P + G + 1;
      end
      m_lost = (clear_lost ? 4'b0 : m_lost) | (r & m_pend & ~c);
      m_pend = (m_pend & ~c) | r;
      h3 = h2; h2 = h1; h1 = int_in;
    end
  end

  // Compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    logic [3:0] e_out;
    logic       e_busy;
    if (rst !== 1'b1) begin
      e_out  = (m_act && (m_now - m_start) < P) ? 4'(1 << m_src) : 4'b0;
      e_busy = m_act && (m_now - m_start) < (P + G);
      chk("model_int_out", int_out, e_out);
      chk("model_pending", pending, m_pend);
      chk("model_lost", lost, m_lost);
      chk("model_busy", busy, e_busy);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int         nout, nbusy;
    logic [3:0] rec [20];

    rst = 1'b1; int_in = '0; int_mask = 4'hF; clear_lost = 1'b0;
    wait_neg(3);
    chk("reset_int_out", int_out, 4'b0);
    chk("reset_pending", pending, 4'b0);
    chk("reset_lost", lost, 4'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    wait_neg(5);

    // Single event on frameDrawn, held high
    int_in = 4'b1000;
    wait_neg(3);
    chk("single_pend_k2", pending, 4'b1000);
    chk("single_out_k2", int_out, 4'b0);
    wait_neg(1);
    chk("single_out_k3", int_out, 4'b1000);
    chk("single_pend_k3", pending, 4'b0);
    nout = 0; nbusy = 0;
    for (int j = 0; j < 20; j++) begin
      if (int_out == 4'b1000) nout++;
      if (busy) nbusy++;
      wait_neg(1);
    end
    chk("single_pulse_len", nout, P);
    chk("single_busy_len", nbusy, P + G);
    int_in = '0;
    wait_neg(10);

    // Priority: sources 0 and 2 together
    int_in = 4'b0101;
    wait_neg(4);
    for (int j = 0; j < 20; j++) begin
      rec[j] = int_out;
      wait_neg(1);
    end
    chk("prio_first0", rec[0], 4'b0001);
    chk("prio_first3", rec[3], 4'b0001);
    chk("prio_end1", rec[4], 4'b0000);
    chk("prio_gap_last", rec[12], 4'b0000);
    chk("prio_second0", rec[13], 4'b0100);
    chk("prio_second3", rec[16], 4'b0100);
    chk("prio_end2", rec[17], 4'b0000);
    chk("prio_lost", lost, 4'b0);
    int_in = '0;
    wait_neg(10);

    // Lost event: source 1 edges twice while source 0 is being served
    int_in = 4'b0001;
    wait_neg(4);
    chk("lost_first", int_out, 4'b0001);
    int_in = 4'b0010; wait_neg(3);
    int_in = 4'b0000; wait_neg(3);
    int_in = 4'b0010; wait_neg(3);
    int_in = 4'b0000;
    nout = 0;
    for (int j = 0; j < 30; j++) begin
      if (int_out == 4'b0010) nout++;
      wait_neg(1);
    end
    chk("lost_one_pulse", nout, P);
    chk("lost_flag", lost, 4'b0010);
    clear_lost = 1'b1; wait_neg(1); clear_lost = 1'b0;
    chk("lost_cleared", lost, 4'b0);
    wait_neg(5);

    // Masked edge is discarded
    int_mask = 4'b1110; int_in = 4'b0001;
    nout = 0;
    for (int j = 0; j < 10; j++) begin
      if (int_out != 4'b0) nout++;
      wait_neg(1);
    end
    chk("mask_no_pulse", nout, 0);
    chk("mask_no_pend", pending, 4'b0);
    int_in = '0; wait_neg(5);
    int_mask = 4'hF; wait_neg(5);

    // Pending held while masked, served right after unmask
    int_in = 4'b0100;
    wait_neg(3);
    chk("hold_pend_set", pending, 4'b0100);
    int_mask = 4'b1011;
    nout = 0;
    for (int j = 0; j < 20; j++) begin
      wait_neg(1);
      if (int_out != 4'b0) nout++;
    end
    chk("hold_no_pulse", nout, 0);
    chk("hold_pend_kept", pending, 4'b0100);
    int_mask = 4'hF;
    wait_neg(1);
    chk("hold_unmask_out", int_out, 4'b0100);
    int_in = '0;
    wait_neg(20);

    // New edge on source 1 lands on its own selection edge
    int_in = 4'b0011;
    wait_neg(3);
    int_in = 4'b0000;
    wait_neg(11);
    int_in = 4'b0010;
    wait_neg(3);
    chk("sbc_out", int_out, 4'b0010);
    chk("sbc_pend", pending, 4'b0010);
    chk("sbc_lost", lost, 4'b0);
    nout = 0;
    for (int j = 0; j < 30; j++) begin
      if (int_out == 4'b0010) nout++;
      wait_neg(1);
    end
    chk("sbc_two_pulses", nout, 2 * P);
    chk("sbc_lost_end", lost, 4'b0);
    int_in = '0;
    wait_neg(10);

    // Asynchronous reset in the middle of a pulse
    int_in = 4'b1100;
    wait_neg(5);
    int_in = '0;
    chk("rst_pre_out", int_out, 4'b0100);
    chk("rst_pre_pend", pending, 4'b1000);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_out", int_out, 4'b0);
    chk("rst_mid_pend", pending, 4'b0);
    chk("rst_mid_lost", lost, 4'b0);
    chk("rst_mid_busy", busy, 1'b0);
    wait_neg(1);
    rst = 1'b0;
    nout = 0;
    for (int j = 0; j < 30; j++) begin
      if (int_out != 4'b0) nout++;
      wait_neg(1);
    end
    chk("rst_no_pulse", nout, 0);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) int_in[b] = ~int_in[b];
      if ($urandom_range(63) == 0) int_mask = 4'($urandom);
      else if ($urandom_range(15) == 0) int_mask = 4'hF;
      clear_lost = ($urandom_range(19) == 0);
      if ($urandom_range(999) == 0) begin
        #2 rst = 1'b1;
        wait_neg(1);
        rst = 1'b0;
      end else begin
        wait_neg(1);
      end
    end

    clear_lost = 1'b0;
    rst = 1'b0;
    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
